// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 receive path.
// Bit timings assume a 50 MHz system clock.
package ws2812_pkg;

  localparam int PIXEL_W        = 24;
  localparam int BIT_CNT_W      = $clog2(PIXEL_W);

  localparam int T0H_CLK        = 20;
  localparam int T1H_CLK        = 40;
  localparam int BIT_PERIOD_CLK = 62;
  localparam int LATCH_CLK      = 2500;

  localparam int MAX_POS_DEF    = 109;
  localparam int BIT_THRESH_DEF = 30;
  localparam int MIN_HIGH_DEF   = 5;
  localparam int MAX_HIGH_DEF   = 60;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer plus registered edge detect for the raw line.
// Ports: clk, reset (async, high), din (raw) -> din_s level, rise/fall strobes.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // prev_q is the level aligned with the registered strobes
  assign din_s = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 GRB bitstream decoder: pulse-width bit decode, pixel and frame framing.
// Ports: clk, reset, din -> pixel_data/index/valid, frame_done/count/overflow, bit_error.
module ws2812_rx_decoder
  import ws2812_pkg::*;
#(
  parameter  int MAX_POS        = MAX_POS_DEF,
  parameter  int BIT_THRESH_CLK = BIT_THRESH_DEF,
  parameter  int MIN_HIGH_CLK   = MIN_HIGH_DEF,
  parameter  int MAX_HIGH_CLK   = MAX_HIGH_DEF,
  parameter  int LATCH_CLK_CNT  = LATCH_CLK,
  localparam int IDX_W          = $clog2(MAX_POS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic [IDX_W-1:0]   pixel_index,
  output logic               pixel_valid,
  output logic               frame_done,
  output logic [IDX_W-1:0]   frame_count,
  output logic               frame_overflow,
  output logic               bit_error
);

  localparam int LW = $clog2(LATCH_CLK_CNT + 1);
  localparam int HW = $clog2(MAX_HIGH_CLK + 1);

  localparam logic [LW-1:0] LATCH_V  = LW'(LATCH_CLK_CNT);
  localparam logic [HW-1:0] THRESH_V = HW'(BIT_THRESH_CLK);
  localparam logic [HW-1:0] MIN_V    = HW'(MIN_HIGH_CLK);
  localparam logic [HW-1:0] MAX_V    = HW'(MAX_HIGH_CLK);
  localparam logic [IDX_W-1:0] POS_V = IDX_W'(MAX_POS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PIXEL_W - 1);

  logic din_s, rise, fall;

  rx_state_e state_q, state_d;

  logic [LW-1:0]        low_cnt_q, low_cnt_d, low_inc;
  logic [HW-1:0]        high_cnt_q, high_cnt_d, high_inc;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PIXEL_W-1:0]   shift_q, shift_d, shift_nx;
  logic [IDX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 pv_pend_q, pv_pend_d;

  logic [PIXEL_W-1:0]   pdata_q, pdata_d;
  logic [IDX_W-1:0]     pidx_q, pidx_d;
  logic                 pv_q, pv_d;
  logic                 fd_q, fd_d;
  logic [IDX_W-1:0]     fcnt_q, fcnt_d;
  logic                 fovf_q, fovf_d;
  logic                 berr_q, berr_d;

  logic latch_hit, glitch, stuck, bit_val;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  // shared event decode
  always_comb begin
    low_inc   = (low_cnt_q == LATCH_V) ? low_cnt_q
                                       : low_cnt_q + LW'(1);
    // fires once per gap: only on the step into saturation
    latch_hit = (low_cnt_q != LATCH_V) && (low_inc == LATCH_V);
    high_inc  = high_cnt_q + HW'(1);
    bit_val   = (high_cnt_q >= THRESH_V);
    glitch    = (state_q == ST_HIGH) && fall
                && (high_cnt_q < MIN_V);
    stuck     = (state_q == ST_HIGH) && !fall
                && (high_inc >= MAX_V);
    shift_nx  = {shift_q[PIXEL_W-2:0], bit_val};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC: if (!din_s && latch_hit) state_d = ST_LOW;
      ST_LOW:  if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (glitch || stuck) state_d = ST_SYNC;
        else if (fall)       state_d = ST_LOW;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pix_cnt_d  = pix_cnt_q;
    ovf_d      = ovf_q;
    pv_pend_d  = 1'b0;
    pdata_d    = pdata_q;
    pidx_d     = pidx_q;
    pv_d       = pv_pend_q;
    fd_d       = 1'b0;
    fcnt_d     = fcnt_q;
    fovf_d     = fovf_q;
    berr_d     = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        low_cnt_d = din_s ? '0 : low_inc;
        bit_cnt_d = '0;
        pix_cnt_d = '0;
        ovf_d     = 1'b0;
      end
      ST_LOW: begin
        if (rise) begin
          high_cnt_d = HW'(1);
        end else begin
          low_cnt_d = low_inc;
          if (latch_hit) begin
            berr_d = (bit_cnt_q != '0);
            if (pix_cnt_q != '0) begin
              fd_d   = 1'b1;
              fcnt_d = pix_cnt_q;
              fovf_d = ovf_q;
            end
            pix_cnt_d = '0;
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
          end
        end
      end
      ST_HIGH: begin
        if (glitch || stuck) begin
          berr_d    = 1'b1;
          low_cnt_d = '0;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          ovf_d     = 1'b0;
        end else if (fall) begin
          shift_d   = shift_nx;
          low_cnt_d = LW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < POS_V) begin
              pv_pend_d = 1'b1;
              pdata_d   = shift_nx;
              pidx_d    = pix_cnt_q;
              pix_cnt_d = pix_cnt_q + IDX_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          high_cnt_d = high_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pix_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      pv_pend_q  <= 1'b0;
      pdata_q    <= '0;
      pidx_q     <= '0;
      pv_q       <= 1'b0;
      fd_q       <= 1'b0;
      fcnt_q     <= '0;
      fovf_q     <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pix_cnt_q  <= pix_cnt_d;
      ovf_q      <= ovf_d;
      pv_pend_q  <= pv_pend_d;
      pdata_q    <= pdata_d;
      pidx_q     <= pidx_d;
      pv_q       <= pv_d;
      fd_q       <= fd_d;
      fcnt_q     <= fcnt_d;
      fovf_q     <= fovf_d;
      berr_q     <= berr_d;
    end
  end

  assign pixel_data     = pdata_q;
  assign pixel_index    = pidx_q;
  assign pixel_valid    = pv_q;
  assign frame_done     = fd_q;
  assign frame_count    = fcnt_q;
  assign frame_overflow = fovf_q;
  assign bit_error      = berr_q;

endmodule
